// File: rtl/hex_line_formatter.sv
// Formats one binary word as uppercase ASCII hex followed by CR LF into a flat
// character buffer, then hands the line to a transmit block via start/done.
module hex_line_formatter #(
    parameter int DATA_WIDTH  = 32,
    parameter int BUFFER_SIZE = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               i_valid,
    input  logic [DATA_WIDTH-1:0]              i_data,
    output logic                               o_ready,
    output logic [8*BUFFER_SIZE-1:0]           o_data,
    output logic [$clog2(BUFFER_SIZE+1)-1:0]   o_data_length,
    output logic                               o_start,
    input  logic                               i_tx_done,
    output logic [7:0]                         o_drop_count
);

    localparam int NIBBLES = DATA_WIDTH / 4;
    localparam int LEN_W   = $clog2(BUFFER_SIZE + 1);
    localparam int CNT_W   = $clog2(NIBBLES + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FORMAT    = 3'd1,
        TERM      = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0]         nib_q, nib_d;
    logic [8*BUFFER_SIZE-1:0] buf_q, buf_d;
    logic [7:0]               drop_q, drop_d;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        nib_d   = nib_q;
        buf_d   = buf_q;
        drop_d  = drop_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    shift_d = i_data;
                    nib_d   = '0;
                    state_d = FORMAT;
                end
            end
            FORMAT: begin
                buf_d[8*int'(nib_q) +: 8] = hex_char(shift_q[DATA_WIDTH-1 -: 4]);
                shift_d = shift_q << 4;
                nib_d   = nib_q + 1'b1;
                if (nib_q == CNT_W'(NIBBLES - 1)) begin
                    state_d = TERM;
                end
            end
            TERM: begin
                buf_d[8*NIBBLES +: 8]     = 8'h0D;
                buf_d[8*(NIBBLES+1) +: 8] = 8'h0A;
                state_d = START;
            end
            START: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // done pulses seen in any other state are deliberately ignored
                if (i_tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (i_valid && (state_q != IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            nib_q   <= '0;
            buf_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            nib_q   <= nib_d;
            buf_q   <= buf_d;
            drop_q  <= drop_d;
        end
    end

    assign o_ready       = (state_q == IDLE);
    assign o_start       = (state_q == START);
    assign o_data        = buf_q;
    assign o_data_length = LEN_W'(NIBBLES + 2);
    assign o_drop_count  = drop_q;

endmodule

// File: tb/tb_hex_line_formatter.sv
// Directed bench for hex_line_formatter: line formatting, handshake, drop
// counter saturation and reset abort.
module tb_hex_line_formatter;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         i_valid = 1'b0;
    logic [31:0]  i_data = '0;
    logic         i_tx_done = 1'b0;
    logic         o_ready;
    logic [127:0] o_data;
    logic [4:0]   o_data_length;
    logic         o_start;
    logic [7:0]   o_drop_count;

    int total = 0;
    int bad   = 0;

    hex_line_formatter #(.DATA_WIDTH(32), .BUFFER_SIZE(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_ready       (o_ready),
        .o_data        (o_data),
        .o_data_length (o_data_length),
        .o_start       (o_start),
        .i_tx_done     (i_tx_done),
        .o_drop_count  (o_drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] d);
        i_valid = 1'b1;
        i_data  = d;
        step();
        i_valid = 1'b0;
    endtask

    // returns number of edges until o_start is seen, -1 on timeout
    task automatic wait_start(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (o_start) begin
                n = i;
                break;
            end
        end
    endtask

    localparam logic [127:0] LINE_DEADBEEF = 128'h000000000000_0A0D_4645_4542_4441_4544;
    localparam logic [127:0] LINE_09AF0000 = 128'h000000000000_0A0D_3030_3030_4641_3930;
    localparam logic [127:0] LINE_CAFE0123 = 128'h000000000000_0A0D_3332_3130_4546_4143;

    initial begin
        int n;
        int starts;
        int ready_seen;
        logic [127:0] snap;

        // reset state
        step();
        step();
        check("rst_ready", o_ready, 1);
        check("rst_start", o_start, 0);
        check("rst_data", o_data, 0);
        check("rst_drop", o_drop_count, 0);
        check("rst_len", o_data_length, 10);
        reset_n = 1'b1;
        step();

        // basic line plus long handshake wait
        accept(32'hDEADBEEF);
        check("busy_after_accept", o_ready, 0);
        wait_start(n);
        check("basic_latency", n, 9);
        check("basic_data", o_data, LINE_DEADBEEF);
        check("basic_len", o_data_length, 10);
        step();
        check("start_one_cycle", o_start, 0);
        snap = o_data;
        ready_seen = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (o_ready || o_start) ready_seen++;
        end
        check("wait_hold_ready", ready_seen, 0);
        check("wait_hold_data", o_data, snap);
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        check("done_ready", o_ready, 1);
        check("no_drop_idle", o_drop_count, 0);

        // digit/letter boundaries with early done pulses
        accept(32'h09AF0000);
        step();
        step();
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        wait_start(n);
        check("early_done_fmt_latency", n, 6);
        check("boundary_data", o_data, LINE_09AF0000);
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        check("early_done_start", o_ready, 0);
        for (int i = 0; i < 5; i++) step();
        check("still_waiting", o_ready, 0);
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        check("late_done_ready", o_ready, 1);

        // three back-to-back lines with valid held: 11 busy cycles each
        i_valid   = 1'b1;
        i_data    = 32'h00000001;
        i_tx_done = 1'b1;
        starts    = 0;
        for (int i = 0; i < 36; i++) begin
            step();
            if (o_start) starts++;
        end
        i_valid   = 1'b0;
        i_tx_done = 1'b0;
        check("three_lines_starts", starts, 3);
        check("three_lines_ready", o_ready, 1);
        check("drop_33", o_drop_count, 33);

        // saturation: 300 more busy cycles would wrap to 77
        i_valid = 1'b1;
        step();
        for (int i = 0; i < 300; i++) step();
        check("drop_sat", o_drop_count, 255);
        i_valid   = 1'b0;
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        check("sat_exit_ready", o_ready, 1);
        check("sat_hold", o_drop_count, 255);

        // reset in the middle of FORMAT
        accept(32'h12345678);
        step();
        step();
        step();
        check("partial_chars", o_data[23:0], 24'h333231);
        reset_n = 1'b0;
        #1;
        check("abort_data", o_data, 0);
        check("abort_ready", o_ready, 1);
        check("abort_start", o_start, 0);
        check("abort_drop", o_drop_count, 0);
        step();
        reset_n = 1'b1;
        starts = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (o_start) starts++;
        end
        check("abort_no_start", starts, 0);
        accept(32'hCAFE0123);
        wait_start(n);
        check("post_reset_latency", n, 9);
        check("post_reset_data", o_data, LINE_CAFE0123);
        i_tx_done = 1'b1;
        step();
        step();
        i_tx_done = 1'b0;
        check("post_reset_ready", o_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_line_formatter.md
# hex_line_formatter

- Upstream feeder for `transmit_block`.
- Accepts one binary word per valid/ready handshake.
- Formats the word as uppercase ASCII hex, MSB nibble first, followed by CR LF, into a flattened character buffer.
- Pulses `start` for the transmit block, then holds the buffer stable until the transmit block's `done` returns. This lets debug logic print register values over the UART.

## Interface

- `DATA_WIDTH`, 32: input word width. Must be a multiple of 4. `NIBBLES = DATA_WIDTH/4`.
- `BUFFER_SIZE`, 16: characters in the output buffer. Must be ≥ `NIBBLES+2`.
- `clk`  input  1  sole clock, rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `i_valid`  input  1  `i_data` is offered.
- `i_data`  input  `DATA_WIDTH`  word to print.
- `o_ready`  output  1  block can accept a word.
- `o_data`  output  `8*BUFFER_SIZE`  character buffer. Char k occupies `[8k+7:8k]`.
- `o_data_length`  output  `$clog2(BUFFER_SIZE+1)`  valid characters, constant `NIBBLES+2`.
- `o_start`  output  1  one-cycle request to the transmit block.
- `i_tx_done`  input  1  transmit block finished the line.
- `o_drop_count`  output  8  saturating count of offers refused while busy.

## Operation

- **States:**
  - `IDLE`: `o_ready=1`.
  - `FORMAT`: one nibble per cycle.
  - `TERM`: writes CR/LF.
  - `START`: `o_start=1`.
  - `WAIT_DONE`: waits for `i_tx_done`.
- **IDLE:**
  - On `i_valid && o_ready`: capture `i_data` into a shift register, clear nibble counter to 0, go to `FORMAT`.
  - Buffer entries ≥ `NIBBLES+2` are held at 0x00 at all times.
- **FORMAT:**
  - Each cycle, take the top nibble n of the shift register and write char `nibble counter` as 0x30+n for n ≤ 9, or 0x37+n for n ≥ 10.
  - Shift left 4 and increment the counter.
  - After `NIBBLES` writes, go to `TERM`.
- **TERM:** write 0x0D at index `NIBBLES` and 0x0A at index `NIBBLES+1`, then go to `START`.
- **START:** `o_start` is decoded from the state register, so it is high for exactly one cycle. Always go to `WAIT_DONE`.
- **WAIT_DONE:** on a cycle where `i_tx_done=1`, go to `IDLE`. Buffer contents stay unchanged until the next accept.
- **`i_tx_done` outside `WAIT_DONE`:** ignored. No state change, no latching.
- **`o_drop_count`:**
  - Increments on every cycle with `i_valid=1 && o_ready=0`.
  - Saturates at 255 and never wraps.
  - Cleared only by reset.
- **`o_data_length`:** constant `NIBBLES+2`. Not registered state.

## Timing

- **Reset (async assert, sync release):**
  - state `IDLE`, `o_ready=1`, `o_start=0`.
  - `o_data` all 0x00, shift register 0, nibble counter 0, `o_drop_count=0`.
- **Latency from the accept edge E0:**
  - Chars written at edges E1..E`NIBBLES`; CR/LF at edge E(`NIBBLES`+1).
  - `o_start` high during the cycle after E(`NIBBLES`+1). For the defaults that is after E9, i.e. 9 cycles after accept.
  - The buffer is complete and stable while `o_start` is high.
- **Return to idle:** `o_ready` rises the cycle after the edge that samples `i_tx_done=1` in `WAIT_DONE`. Minimum accept-to-accept interval is `NIBBLES+4` cycles.
- **Busy window:** `o_ready` is low from the cycle after accept until the return to `IDLE`. An offer at E0 is accepted and never counted as a drop.
- **Reset mid-operation:** any state returns to `IDLE` immediately on `reset_n` low. The partially written buffer is cleared, and no `o_start` is issued for the aborted word.
- **`i_tx_done` coincident with entry to `WAIT_DONE`:** only sampled once the state is `WAIT_DONE`. A pulse in the `START` cycle is ignored.

## Test plan

- **Basic line:** accept 0xDEADBEEF at cycle 0. Expect:
  - `o_data` bytes 0..9 = 44 45 41 44 42 45 45 46 0D 0A, bytes 10..15 = 00.
  - `o_data_length=10`.
  - `o_start` high for exactly one cycle, 9 cycles after accept.
- **Digit/letter boundaries:** accept 0x09AF0000. Expect bytes 0..7 = 30 39 41 46 30 30 30 30, then 0D 0A.
- **Handshake:** hold `i_tx_done` low for 200 cycles after `o_start`. Expect:
  - state stays `WAIT_DONE`, `o_ready=0`, buffer unchanged.
  - A `i_tx_done` pulse makes `o_ready=1` next cycle.
- **Early done:** pulse `i_tx_done` during `FORMAT` and during the `START` cycle. Expect no effect; the block still waits for a later pulse.
- **Drop counter:** hold `i_valid=1` continuously across 3 full lines. Expect:
  - `o_drop_count` equals the number of busy cycles.
  - Forcing 300 busy cycles reads 255, with no wrap.
- **Reset mid-FORMAT:** assert `reset_n=0` after 3 nibbles are written. Expect:
  - Immediately: `o_data` all 00, `o_ready=1`, `o_start` never asserted.
  - A new word then formats correctly from index 0.
